// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW hazards, taken branches and memory waits.
// Optional build macro FORWARDING_EN: only load-use in EX stalls; MEM results are forwarded.
module pipeline_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 16,
  parameter int MAX_MEM_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_src1,
  input  logic [REG_AW-1:0] i_id_src2,
  input  logic              i_id_two_src,
  input  logic [REG_AW-1:0] i_exe_dest,
  input  logic              i_exe_wb_en,
  input  logic              i_exe_mem_read,
  input  logic [REG_AW-1:0] i_mem_dest,
  input  logic              i_mem_wb_en,
  input  logic              i_br_taken,
  input  logic              i_mem_req,
  input  logic              i_mem_ready,
  output logic              o_pc_freeze,
  output logic              o_ifid_freeze,
  output logic              o_ifid_flush,
  output logic              o_idex_bubble,
  output logic              o_pipe_freeze,
  output logic              o_mem_timeout,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  localparam int WCNT_W = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_MEM_WAIT);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR
  } state_t;

  state_t            r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_mem_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_match_exe;
  logic w_hazard;
  logic w_pipe_freeze;
  logic w_do_flush;
  logic w_do_stall;
  logic w_unused_fwd;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign w_match_exe = i_exe_wb_en && (i_exe_dest != '0) &&
                       ((i_exe_dest == i_id_src1) ||
                        (i_id_two_src && (i_exe_dest == i_id_src2)));

`ifdef FORWARDING_EN
  assign w_hazard     = i_id_valid && i_exe_mem_read && w_match_exe;
  assign w_unused_fwd = i_mem_wb_en ^ (^i_mem_dest);
`else
  logic w_match_mem;

  assign w_match_mem  = i_mem_wb_en && (i_mem_dest != '0) &&
                        ((i_mem_dest == i_id_src1) ||
                         (i_id_two_src && (i_mem_dest == i_id_src2)));
  assign w_hazard     = i_id_valid && (w_match_exe || w_match_mem);
  assign w_unused_fwd = i_exe_mem_read;
`endif

  // Freeze drops in the very cycle memory reports ready.
  always_comb begin
    w_pipe_freeze = 1'b0;
    case (r_state)
      ST_IDLE: w_pipe_freeze = i_mem_req && !i_mem_ready;
      ST_WAIT: w_pipe_freeze = !i_mem_ready;
      ST_ERR:  w_pipe_freeze = 1'b1;
      default: w_pipe_freeze = 1'b0;
    endcase
  end

  assign w_do_flush = !w_pipe_freeze && i_br_taken;
  assign w_do_stall = !w_pipe_freeze && !i_br_taken && w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wcnt        <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_mem_req && !i_mem_ready) begin
            r_state <= ST_WAIT;
            r_wcnt  <= WCNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (i_mem_ready) begin
            r_state <= ST_IDLE;
          end else if (r_wcnt == WCNT_LAST) begin
            r_state       <= ST_ERR;
            r_mem_timeout <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
          end
        end
        ST_ERR: r_state <= ST_ERR;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_do_stall && (r_stall_cnt != CNT_SAT)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_do_flush && (r_flush_cnt != CNT_SAT)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pc_freeze   = !rst && (w_pipe_freeze || w_do_stall);
  assign o_ifid_freeze = !rst && (w_pipe_freeze || w_do_stall);
  assign o_ifid_flush  = !rst && w_do_flush;
  assign o_idex_bubble = !rst && (w_do_flush || w_do_stall);
  assign o_pipe_freeze = !rst && w_pipe_freeze;
  assign o_mem_timeout = !rst && r_mem_timeout;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;

endmodule
